winograd_f5_4: RTL and testbench
================================

Name: winograd_f5_4

Overview:
- Fixed-coefficient 1-D Winograd minimal-filtering engine, F(5,4).
- Each cycle it accepts an 8-sample tile of signed 10-bit data and produces the 5 valid outputs of correlating the tile with a 4-tap constant filter.
- Fully pipelined: one tile per clock. It sits in the convolution datapath between the tile packer and the output accumulator.

Parameters:
- DW, 10, width of each data sample and each output sample (two's complement).
- G0, 1, filter tap 0 (signed integer constant).
- G1, -2, filter tap 1.
- G2, 3, filter tap 2.
- G3, 1, filter tap 3.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset.
- D  input  8*DW  packed input tile; d0 = D[79:70] (MSB field) … d7 = D[9:0].
- Z  output  5*DW  packed results; z0 = Z[49:40] (MSB field) … z4 = Z[9:0].

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Function: z_i = d_i*G0 + d_(i+1)*G1 + d_(i+2)*G2 + d_(i+3)*G3, for i = 0..4.
  - Exact integer result, then wrapped modulo 2^DW into DW-bit two's complement.
  - No saturation and no rounding; Z is bit-exact with this formula.
- Structure:
  - Input transform B^T: 8x8, interpolation points 0, ±1, ±2, ±3, ∞.
  - 8 element-wise multiplies by pre-transformed filter constants. These constants are scaled to integers by a common factor S and computed at elaboration.
  - Output transform A^T: 5x8.
  - Exact division by S; the numerator is always an exact multiple of S.
  - Internal widths are sized so no intermediate value overflows; the only truncation is the final wrap to DW bits.
- Pipeline stages, all registered:
  - S1: capture D.
  - S2: input transform.
  - S3: multiply.
  - S4: output transform, divide, wrap into the Z register.
- Latency: a tile sampled at rising edge k appears on Z after edge k+3, i.e. 4 edges including the capture.
- Throughput: one new tile per cycle. There is no handshake or valid signal; D is sampled every cycle.
- Reset:
  - While rst = 0 at a rising edge, all pipeline registers and Z clear to 0.
  - Reset mid-stream discards every in-flight tile.
  - The first post-reset tile appears 4 edges after the capture edge, i.e. the first edge with rst = 1.
- Constant D: Z remains constant from latency onward.
- Extremes:
  - D all 511 (0x1FF per field): each true sum is 1533, so Z fields = 509.
  - D all -512: each true sum is -1536, so Z fields = -512 (10'b1000000000).

Decomposition:
- Shared package wc_pkg:
  - DW, N_IN = 8, N_OUT = 5, R = 4.
  - Default taps G0..G3.
  - Scale factor S and the 8 transformed-filter constants (as localparam functions).
  - Typedef for the packed tile type and the output-vector type.
- One sub-module is natural: wc_xform, a purely combinational matrix-vector transform block parameterized by matrix constants. Instantiate it twice: B^T in S2, A^T in S3/S4.
- The multiply stage stays inline.

Test Plan:
- Reset: hold rst = 0 for 2 edges with arbitrary D -> Z = 0. Release; the first valid Z arrives 4 edges after the first edge with rst = 1.
- Tile 1: D = [2, -10, 3, 4, -13, -18, -16, -28] -> after latency, Z = [35, -17, -62, -40, -53].
- Tile 2 (back-to-back with tile 1, then held): D = [-19, -6, 3, -9, -12, 11, -4, 0] -> after latency, Z = [-7, -51, -4, 44, -46], exactly one cycle after tile 1's result.
- Wrap: D all 511 -> Z all 509. D all -512 -> Z all -512. D all 0 -> Z all 0.
- Mid-stream reset: stream tiles 1 and 2 on consecutive cycles, then assert rst for 1 edge.
  - Required: Z = 0 on the reset edge.
  - No stale tile result appears afterwards.
  - The next tile applied with rst = 1 appears after 4 edges.
- Random: 1000 random tiles, one per cycle -> Z matches the wrapped direct-correlation formula with latency 4.

Source files
------------

// File: rtl/wc_pkg.sv
// Shared constants, types and elaboration-time builders for the F(5,4) Winograd engine.
// Transform matrices come from Toom-Cook interpolation at points 0, 1, -1, 2, -2, 3, -3 and infinity.
package wc_pkg;
    localparam int DW    = 10;
    localparam int N_OUT = 5;
    localparam int R     = 4;
    localparam int N_IN  = N_OUT + R - 1;
    localparam int N_PT  = N_IN - 1;
    localparam int CW    = 32;
    localparam int VW    = 24;
    localparam int PW    = 40;

    localparam int G0 = 1;
    localparam int G1 = -2;
    localparam int G2 = 3;
    localparam int G3 = 1;

    typedef logic [N_IN*DW-1:0]       tile_t;
    typedef logic [N_OUT*DW-1:0]      zvec_t;
    typedef logic [N_IN*VW-1:0]       vvec_t;
    typedef logic [N_IN*PW-1:0]       pvec_t;
    typedef logic [N_OUT*PW-1:0]      svec_t;
    typedef logic [N_IN*N_IN*CW-1:0]  bt_mat_t;
    typedef logic [N_OUT*N_IN*CW-1:0] at_mat_t;

    // Point index j maps to 0, 1, -1, 2, -2, 3, -3; index N_PT stands for infinity.
    function automatic int pt(input int j);
        return (j % 2 == 1) ? (j + 1) / 2 : -(j / 2);
    endfunction

    function automatic int den(input int j);
        int p;
        p = 1;
        for (int k = 0; k < N_PT; k++)
            if (k != j) p = p * (pt(j) - pt(k));
        return p;
    endfunction

    function automatic int gcd(input int a, input int b);
        int x, y, t;
        x = (a < 0) ? -a : a;
        y = (b < 0) ? -b : b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int scale();
        int s, a;
        s = 1;
        for (int j = 0; j < N_PT; j++) begin
            a = (den(j) < 0) ? -den(j) : den(j);
            s = s / gcd(s, a) * a;
        end
        return s;
    endfunction

    function automatic int g_eval(input int p);
        return G0 + p * (G1 + p * (G2 + p * G3));
    endfunction

    function automatic int kf(input int j);
        if (j == N_PT) return scale() * G3;
        return (scale() / den(j)) * g_eval(pt(j));
    endfunction

    // Coefficient of x^t in prod over the other points of (x - p_k); the infinity row is the full node polynomial.
    function automatic int bt_coef(input int j, input int t);
        logic [N_IN-1:0][31:0] c;
        c    = '0;
        c[0] = 32'd1;
        for (int k = 0; k < N_PT; k++) begin
            if (k != j) begin
                for (int i = N_IN - 1; i > 0; i--)
                    c[i] = c[i-1] - 32'(pt(k)) * c[i];
                c[0] = -32'(pt(k)) * c[0];
            end
        end
        return int'(c[t]);
    endfunction

    function automatic int at_coef(input int i, input int j);
        int v;
        if (j == N_PT) return (i == N_OUT - 1) ? 1 : 0;
        v = 1;
        for (int k = 0; k < i; k++) v = v * pt(j);
        return v;
    endfunction

    function automatic bt_mat_t bt_mat();
        bt_mat_t m;
        m = '0;
        for (int r = 0; r < N_IN; r++)
            for (int c = 0; c < N_IN; c++)
                m[(r*N_IN+c)*CW +: CW] = bt_coef(r, c);
        return m;
    endfunction

    function automatic at_mat_t at_mat();
        at_mat_t m;
        m = '0;
        for (int r = 0; r < N_OUT; r++)
            for (int c = 0; c < N_IN; c++)
                m[(r*N_IN+c)*CW +: CW] = at_coef(r, c);
        return m;
    endfunction

    function automatic int s_shift();
        int s, n;
        s = scale();
        n = 0;
        while (s % 2 == 0) begin
            s = s / 2;
            n++;
        end
        return n;
    endfunction

    // Inverse of the odd part of S modulo 2^32 by Newton iteration; low DW bits are what matter.
    function automatic logic [DW-1:0] s_inv();
        logic [31:0] o, x;
        o = 32'(scale() >> s_shift());
        x = o;
        for (int k = 0; k < 5; k++) x = x * (32'd2 - o * x);
        return x[DW-1:0];
    endfunction
endpackage

// File: rtl/winograd_f5_4_if.sv
// Tile-in / result-out bundle for the F(5,4) engine.
interface winograd_f5_4_if;
    import wc_pkg::*;

    tile_t D;
    zvec_t Z;

    modport master (output D, input Z);
    modport slave  (input D, output Z);
endinterface

// File: rtl/wc_xform.sv
// Combinational constant-matrix times vector; element 0 of both vectors sits in the MSB field.
module wc_xform
    import wc_pkg::*;
#(
    parameter int ROWS = N_IN,
    parameter int COLS = N_IN,
    parameter int IW   = DW,
    parameter int OW   = VW,
    parameter logic [ROWS*COLS*CW-1:0] COEF = '0
) (
    input  logic [COLS*IW-1:0] x,
    output logic [ROWS*OW-1:0] y
);
    logic signed [OW-1:0] acc;

    always_comb begin
        y   = '0;
        acc = '0;
        for (int r = 0; r < ROWS; r++) begin
            acc = '0;
            for (int c = 0; c < COLS; c++)
                acc = acc + OW'(signed'(x[(COLS-1-c)*IW +: IW]))
                          * OW'(signed'(COEF[(r*COLS+c)*CW +: CW]));
            y[(ROWS-1-r)*OW +: OW] = acc;
        end
    end
endmodule

// File: rtl/winograd_f5_4.sv
// Four-stage F(5,4) Winograd correlator: capture, input transform, multiply, output transform.
// One tile per clock, no handshake; results wrap to DW bits.
module winograd_f5_4
    import wc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    winograd_f5_4_if.slave io
);
    localparam bt_mat_t         BT  = bt_mat();
    localparam at_mat_t         AT  = at_mat();
    localparam int              SH  = s_shift();
    localparam logic [DW-1:0]   INV = s_inv();

    tile_t d_q;
    vvec_t v, v_q;
    pvec_t prod, p_q;
    svec_t y;
    zvec_t z_next, z_q;

    wc_xform #(
        .ROWS(N_IN), .COLS(N_IN), .IW(DW), .OW(VW), .COEF(BT)
    ) u_bt (
        .x(d_q),
        .y(v)
    );

    for (genvar j = 0; j < N_IN; j++) begin : g_mul
        localparam int KJ = kf(j);
        assign prod[(N_IN-1-j)*PW +: PW] = PW'(signed'(v_q[(N_IN-1-j)*VW +: VW])) * PW'(KJ);
    end

    wc_xform #(
        .ROWS(N_OUT), .COLS(N_IN), .IW(PW), .OW(PW), .COEF(AT)
    ) u_at (
        .x(p_q),
        .y(y)
    );

    // y is an exact multiple of S: shift out its power of two, then multiply by the odd part's
    // inverse mod 2^DW, which yields the quotient already wrapped to DW bits.
    always_comb begin
        z_next = '0;
        for (int i = 0; i < N_OUT; i++)
            z_next[(N_OUT-1-i)*DW +: DW] = DW'($signed(y[(N_OUT-1-i)*PW +: PW]) >>> SH) * INV;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_q <= '0;
            v_q <= '0;
            p_q <= '0;
            z_q <= '0;
        end else begin
            d_q <= io.D;
            v_q <= v;
            p_q <= prod;
            z_q <= z_next;
        end
    end

    assign io.Z = z_q;
endmodule

// File: tb/tb_winograd_f5_4.sv
// Directed and randomized checks of winograd_f5_4 against a direct-correlation model with a 4-edge window.
module tb_winograd_f5_4;
    import wc_pkg::*;

    logic clk;
    logic rst;
    winograd_f5_4_if bus ();

    winograd_f5_4 dut (.clk(clk), .rst(rst), .io(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int TAPS [4] = '{1, -2, 3, 1};
    localparam int T1 [8] = '{2, -10, 3, 4, -13, -18, -16, -28};
    localparam int T2 [8] = '{-19, -6, 3, -9, -12, 11, -4, 0};
    localparam int Z1 [5] = '{35, -17, -62, -40, -53};
    localparam int Z2 [5] = '{-7, -51, -4, 44, -46};

    int    n_chk = 0;
    int    n_err = 0;
    tile_t hist_d [$];
    bit    hist_r [$];

    task automatic chk(input string tag, input zvec_t got, input zvec_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic tile_t mk_tile(input int a [8]);
        tile_t t;
        for (int j = 0; j < 8; j++) t[(7-j)*10 +: 10] = 10'(a[j]);
        return t;
    endfunction

    function automatic zvec_t mk_z(input int a [5]);
        zvec_t z;
        for (int i = 0; i < 5; i++) z[(4-i)*10 +: 10] = 10'(a[i]);
        return z;
    endfunction

    function automatic tile_t fill(input int v);
        tile_t t;
        for (int j = 0; j < 8; j++) t[j*10 +: 10] = 10'(v);
        return t;
    endfunction

    function automatic zvec_t zfill(input int v);
        zvec_t z;
        for (int i = 0; i < 5; i++) z[i*10 +: 10] = 10'(v);
        return z;
    endfunction

    function automatic tile_t rand_tile();
        tile_t t;
        for (int j = 0; j < 8; j++) begin
            case ($urandom_range(0, 7))
                0:       t[j*10 +: 10] = 10'h1FF;
                1:       t[j*10 +: 10] = 10'h200;
                default: t[j*10 +: 10] = 10'($urandom);
            endcase
        end
        return t;
    endfunction

    // z_i = sum_k d_(i+k) * g_k, wrapped to 10 bits.
    function automatic zvec_t model(input tile_t t);
        zvec_t z;
        int    s;
        for (int i = 0; i < 5; i++) begin
            s = 0;
            for (int k = 0; k < 4; k++)
                s += int'($signed(t[(7-i-k)*10 +: 10])) * TAPS[k];
            z[(4-i)*10 +: 10] = 10'(s);
        end
        return z;
    endfunction

    // Apply one tile across one rising edge, then check Z against the tile captured three edges earlier.
    task automatic cycle(input tile_t d, input bit r);
        zvec_t e;
        int    n;
        bus.D = d;
        rst   = r;
        @(posedge clk);
        hist_d.push_back(d);
        hist_r.push_back(r);
        @(negedge clk);
        n = hist_d.size();
        if (n >= 4) begin
            if (hist_r[n-1] && hist_r[n-2] && hist_r[n-3] && hist_r[n-4])
                e = model(hist_d[n-4]);
            else
                e = '0;
            chk("pipe", bus.Z, e);
        end
    endtask

    initial begin
        bus.D = '0;
        rst   = 1'b0;

        cycle(rand_tile(), 1'b0);
        cycle(rand_tile(), 1'b0);
        chk("reset_z", bus.Z, '0);

        cycle(mk_tile(T1), 1'b1);
        cycle(mk_tile(T2), 1'b1);
        cycle(mk_tile(T2), 1'b1);
        chk("latency_early", bus.Z, '0);
        cycle(mk_tile(T2), 1'b1);
        chk("tile1", bus.Z, mk_z(Z1));
        cycle(mk_tile(T2), 1'b1);
        chk("tile2", bus.Z, mk_z(Z2));
        cycle(mk_tile(T2), 1'b1);
        chk("tile2_held", bus.Z, mk_z(Z2));

        for (int k = 0; k < 4; k++) cycle(fill(511), 1'b1);
        chk("max", bus.Z, zfill(509));
        cycle(fill(511), 1'b1);
        chk("max_held", bus.Z, zfill(509));
        for (int k = 0; k < 4; k++) cycle(fill(-512), 1'b1);
        chk("min", bus.Z, zfill(-512));
        for (int k = 0; k < 4; k++) cycle(fill(0), 1'b1);
        chk("zero", bus.Z, '0);

        cycle(mk_tile(T1), 1'b1);
        cycle(mk_tile(T2), 1'b1);
        cycle(mk_tile(T2), 1'b0);
        chk("rst_edge", bus.Z, '0);
        cycle(mk_tile(T1), 1'b1);
        chk("no_stale1", bus.Z, '0);
        cycle(fill(0), 1'b1);
        chk("no_stale2", bus.Z, '0);
        cycle(fill(0), 1'b1);
        chk("no_stale3", bus.Z, '0);
        cycle(fill(0), 1'b1);
        chk("post_rst", bus.Z, mk_z(Z1));

        for (int k = 0; k < 1000; k++)
            cycle(rand_tile(), ($urandom_range(0, 99) != 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
